tx_char_scheduler: RTL and testbench
====================================

// Module: tx_char_scheduler
// PURPOSE
//  Chooses the next SpaceWire character for the DS transmitter (tx_top char interface), one
//  character per valid/ready transfer. Priority: time-code > FCT > N-char > NULL. Expands
//  NULL (ESC,FCT) and time-code (ESC,byte) into two characters that are never split. Keeps
//  the transmit credit count and the pending-FCT count.
// PARAMETERS
//  MAX_CREDIT   56  max credit; an FCT received above this is a credit error
//  CREDIT_STEP  8   credit added per received FCT
//  FCT_PEND_W   3   width of pending-FCT counter (saturates at 2**W-1)
// PORTS
//  txClk        in   1  transmit clock
//  txReset_n    in   1  async reset, active low
//  en_i         in   1  transmitter enabled; low = link down
//  fct_en_i     in   1  FCTs may be sent
//  run_i        in   1  N-chars and time-codes may be sent
//  tick_i       in   1  1-cycle pulse: request time-code
//  time_i       in   8  time-code value, sampled on tick_i
//  fct_req_i    in   1  1-cycle pulse: queue one outgoing FCT
//  fct_rx_i     in   1  1-cycle pulse: FCT received, grant CREDIT_STEP
//  nc_valid_i   in   1  N-char offered
//  nc_dat_i     in   8  N-char data, or EOP/EEP code in [1:0]
//  nc_lchar_i   in   1  1 = EOP/EEP control char
//  nc_ready_o   out  1  N-char consumed this cycle
//  dat_o        out  8  character to tx_top dat_i
//  lchar_o      out  1  1 = control char, code in dat_o[1:0], dat_o[7:2]=0
//  valid_o      out  1  to tx_top valid_i
//  ready_i      in   1  from tx_top ready_o
//  credit_o     out  6  current credit
//  credit_err_o out  1  sticky credit overflow
// BEHAVIOUR
//  - Codes: FCT=00, EOP=01, EEP=10, ESC=11.
//  - Reset: valid_o=0, dat_o=0, lchar_o=0, credit_o=0, credit_err_o=0, FCT pend=0,
//    time pend=0, state=PICK. nc_ready_o forced 0 while txReset_n low.
//  - Output register loads when load = !valid_o | ready_i. A held character (valid_o=1,
//    ready_i=0) keeps dat_o/lchar_o stable. Loaded char appears 1 cycle after load.
//  - FSM {PICK, NULL2, TIME2}, evaluated on load:
//    NULL2: load FCT ctrl -> PICK.  TIME2: load time_reg, lchar=0 -> PICK; clear time pend.
//    PICK, first match wins:
//      !en_i                              -> valid_o<=0
//      time pend & run_i                  -> ESC, -> TIME2
//      fct_pend>0 & fct_en_i              -> FCT, fct_pend--
//      run_i & nc_valid_i & credit>0      -> N-char, nc_ready_o=1 (comb), credit--
//      else                               -> ESC, -> NULL2
//  - Time: tick_i sets pend and loads time_reg; tick while pend overwrites (latest wins);
//    tick in the clearing cycle leaves pend=1 with the new value.
//  - FCT pend: +1 on fct_req_i (saturating), -1 on FCT load; both in one cycle -> unchanged.
//  - Credit: fct_rx_i adds CREDIT_STEP. If result > MAX_CREDIT: credit unchanged,
//    credit_err_o<=1. fct_rx_i with N-char load in the same cycle -> credit+STEP-1
//    (overflow check on this net value).
//  - en_i low: credit, credit_err_o, FCT pend and time pend clear next cycle. FSM returns
//    to PICK at the next load; a half-sent ESC pair is abandoned. A held char is not
//    retracted: valid_o drops at the next load.
//  - Reset mid-sequence: all state returns to reset values immediately (async).
// STRUCTURE
//  - Package spw_tx_pkg: control-code constants, FSM state encoding, MAX_CREDIT/CREDIT_STEP.
//  - Sub-module tx_credit_counter: credit add/sub, overflow check, sticky error, en_i clear.
//  - All other logic inline.
// TESTING
//  1. en_i=1, others idle, ready_i=1 -> chars alternate {lchar=1,11},{lchar=1,00}; first
//     valid_o one cycle after reset release.
//  2. Two fct_req_i pulses mid-NULL, fct_en_i=1 -> NULL completes, then two FCTs (00),
//     then NULLs. An ESC is never directly followed by an FCT from the queue.
//  3. One fct_rx_i, run_i=1, 10 N-chars offered -> credit_o=8, exactly 8 nc_ready_o,
//     credit_o=0, then NULLs.
//  4. tick_i with time_i=8'h5A during N-char stream with FCT pending -> next chars
//     ESC(11), then 8'h5A lchar=0, then FCT, then N-chars.
//  5. Eight fct_rx_i pulses, no N-chars -> credit_o 8..56; 8th sets credit_err_o=1 and
//     leaves credit_o=56. Dropping en_i clears both.
//  6. ready_i low 5 cycles -> dat_o/lchar_o/valid_o stable. txReset_n low mid time-code ->
//     valid_o=0 and credit_o=0 with no clock edge.

Source files
------------

// File: rtl/spw_tx_pkg.sv
// Shared SpaceWire transmit definitions: control codes, scheduler state encoding
// and flow-control constants.
package spw_tx_pkg;

  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b01;
  localparam logic [1:0] CODE_EEP = 2'b10;
  localparam logic [1:0] CODE_ESC = 2'b11;

  localparam logic [1:0] ST_PICK  = 2'd0;
  localparam logic [1:0] ST_NULL2 = 2'd1;
  localparam logic [1:0] ST_TIME2 = 2'd2;

  localparam int MAX_CREDIT_DEF  = 56;
  localparam int CREDIT_STEP_DEF = 8;

  // Control characters carry their code in the two LSBs, upper bits zero.
  function automatic logic [7:0] ctrl_char(input logic [1:0] code);
    return {6'b000000, code};
  endfunction

endpackage

// File: rtl/tx_char_scheduler_credit.sv
// Transmit credit counter: grants CREDIT_STEP per received FCT, spends one per
// N-char, flags a sticky error on overflow and clears while the link is down.
module tx_credit_counter
  import spw_tx_pkg::*;
#(
  parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
  parameter int CREDIT_STEP = CREDIT_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       fct_rx_i,
  input  logic       take_i,
  output logic [5:0] credit_o,
  output logic       err_o
);

  logic [5:0] credit_q, credit_d;
  logic       err_q, err_d;
  logic [6:0] sum_s;

  // Next credit: the overflow test is made on the net value of grant and spend.
  always_comb begin
    sum_s    = {1'b0, credit_q}
             + (fct_rx_i ? 7'(CREDIT_STEP) : 7'd0)
             - (take_i ? 7'd1 : 7'd0);
    credit_d = credit_q;
    err_d    = err_q;
    if (!en_i) begin
      credit_d = 6'd0;
      err_d    = 1'b0;
    end else if (fct_rx_i && (sum_s > 7'(MAX_CREDIT))) begin
      err_d    = 1'b1;
    end else begin
      credit_d = sum_s[5:0];
    end
  end

  // Credit and error state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= 6'd0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

endmodule

// File: rtl/tx_char_scheduler.sv
// Picks the next SpaceWire character for the DS transmitter: time-code > FCT >
// N-char > NULL, with ESC-prefixed pairs kept together.
module tx_char_scheduler
  import spw_tx_pkg::*;
#(
  parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
  parameter int CREDIT_STEP = CREDIT_STEP_DEF,
  parameter int FCT_PEND_W  = 3
) (
  input  logic       txClk,
  input  logic       txReset_n,
  input  logic       en_i,
  input  logic       fct_en_i,
  input  logic       run_i,
  input  logic       tick_i,
  input  logic [7:0] time_i,
  input  logic       fct_req_i,
  input  logic       fct_rx_i,
  input  logic       nc_valid_i,
  input  logic [7:0] nc_dat_i,
  input  logic       nc_lchar_i,
  output logic       nc_ready_o,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [5:0] credit_o,
  output logic       credit_err_o
);

  localparam logic [FCT_PEND_W-1:0] FCT_PEND_MAX = {FCT_PEND_W{1'b1}};

  logic                  valid_q, valid_d;
  logic [7:0]            dat_q, dat_d;
  logic                  lchar_q, lchar_d;
  logic [1:0]            state_q, state_d;
  logic [FCT_PEND_W-1:0] fct_pend_q, fct_pend_d;
  logic                  time_pend_q, time_pend_d;
  logic [7:0]            time_q, time_d;

  logic                  load_s;
  logic                  take_s;
  logic                  fct_load_s;
  logic                  time_clr_s;
  logic [5:0]            credit_s;

  assign load_s = !valid_q || ready_i;

  // Character selection; a down link abandons any half-sent ESC pair.
  always_comb begin
    valid_d    = valid_q;
    dat_d      = dat_q;
    lchar_d    = lchar_q;
    state_d    = state_q;
    take_s     = 1'b0;
    fct_load_s = 1'b0;
    time_clr_s = 1'b0;
    if (load_s) begin
      if (!en_i) begin
        valid_d = 1'b0;
        state_d = ST_PICK;
      end else begin
        valid_d = 1'b1;
        case (state_q)
          ST_NULL2: begin
            dat_d   = ctrl_char(CODE_FCT);
            lchar_d = 1'b1;
            state_d = ST_PICK;
          end
          ST_TIME2: begin
            dat_d      = time_q;
            lchar_d    = 1'b0;
            time_clr_s = 1'b1;
            state_d    = ST_PICK;
          end
          ST_PICK: begin
            if (time_pend_q && run_i) begin
              dat_d   = ctrl_char(CODE_ESC);
              lchar_d = 1'b1;
              state_d = ST_TIME2;
            end else if ((fct_pend_q != {FCT_PEND_W{1'b0}}) && fct_en_i) begin
              dat_d      = ctrl_char(CODE_FCT);
              lchar_d    = 1'b1;
              fct_load_s = 1'b1;
            end else if (run_i && nc_valid_i && (credit_s != 6'd0)) begin
              take_s  = 1'b1;
              lchar_d = nc_lchar_i;
              dat_d   = nc_lchar_i ? ctrl_char(nc_dat_i[1:0]) : nc_dat_i;
            end else begin
              dat_d   = ctrl_char(CODE_ESC);
              lchar_d = 1'b1;
              state_d = ST_NULL2;
            end
          end
          default: begin
            valid_d = 1'b0;
            state_d = ST_PICK;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // A tick arriving as the time-code completes keeps the request pending.
  always_comb begin
    time_d = tick_i ? time_i : time_q;
    if (!en_i) begin
      time_pend_d = 1'b0;
    end else if (tick_i) begin
      time_pend_d = 1'b1;
    end else if (time_clr_s) begin
      time_pend_d = 1'b0;
    end else begin
      time_pend_d = time_pend_q;
    end
  end

  // Pending outgoing FCTs; a request and a send in the same cycle cancel out.
  always_comb begin
    fct_pend_d = fct_pend_q;
    if (!en_i) begin
      fct_pend_d = {FCT_PEND_W{1'b0}};
    end else begin
      case ({fct_req_i, fct_load_s})
        2'b10: begin
          if (fct_pend_q != FCT_PEND_MAX) begin
            fct_pend_d = fct_pend_q + FCT_PEND_W'(1);
          end else begin
            fct_pend_d = fct_pend_q;
          end
        end
        2'b01:   fct_pend_d = fct_pend_q - FCT_PEND_W'(1);
        default: fct_pend_d = fct_pend_q;
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge txClk or negedge txReset_n) begin
    if (!txReset_n) begin
      valid_q     <= 1'b0;
      dat_q       <= 8'h00;
      lchar_q     <= 1'b0;
      state_q     <= ST_PICK;
      fct_pend_q  <= {FCT_PEND_W{1'b0}};
      time_pend_q <= 1'b0;
      time_q      <= 8'h00;
    end else begin
      valid_q     <= valid_d;
      dat_q       <= dat_d;
      lchar_q     <= lchar_d;
      state_q     <= state_d;
      fct_pend_q  <= fct_pend_d;
      time_pend_q <= time_pend_d;
      time_q      <= time_d;
    end
  end

  tx_credit_counter #(
    .MAX_CREDIT  (MAX_CREDIT),
    .CREDIT_STEP (CREDIT_STEP)
  ) u_credit (
    .clk      (txClk),
    .rst_n    (txReset_n),
    .en_i     (en_i),
    .fct_rx_i (fct_rx_i),
    .take_i   (take_s),
    .credit_o (credit_s),
    .err_o    (credit_err_o)
  );

  assign nc_ready_o = take_s && txReset_n;
  assign dat_o      = dat_q;
  assign lchar_o    = lchar_q;
  assign valid_o    = valid_q;
  assign credit_o   = credit_s;

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Directed plus randomized check of tx_char_scheduler against a transaction-level
// model (priority rules, a queue of forced follow-up characters, plain counters).
module tb_tx_char_scheduler;

  logic       txClk = 1'b0;
  logic       txReset_n;
  logic       en_i, fct_en_i, run_i, tick_i, fct_req_i, fct_rx_i;
  logic [7:0] time_i, nc_dat_i;
  logic       nc_valid_i, nc_lchar_i, ready_i;
  logic       nc_ready_o, lchar_o, valid_o, credit_err_o;
  logic [7:0] dat_o;
  logic [5:0] credit_o;

  always #5 txClk = ~txClk;

  tx_char_scheduler dut (
    .txClk        (txClk),
    .txReset_n    (txReset_n),
    .en_i         (en_i),
    .fct_en_i     (fct_en_i),
    .run_i        (run_i),
    .tick_i       (tick_i),
    .time_i       (time_i),
    .fct_req_i    (fct_req_i),
    .fct_rx_i     (fct_rx_i),
    .nc_valid_i   (nc_valid_i),
    .nc_dat_i     (nc_dat_i),
    .nc_lchar_i   (nc_lchar_i),
    .nc_ready_o   (nc_ready_o),
    .dat_o        (dat_o),
    .lchar_o      (lchar_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .credit_o     (credit_o),
    .credit_err_o (credit_err_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_rdy    = 0;

  // Reference model state: what the link should be showing right now.
  logic       m_valid;
  logic [7:0] m_dat;
  logic       m_lchar;
  int         m_credit;
  logic       m_err;
  int         m_fpend;
  logic       m_tpend;
  logic [7:0] m_time;
  int         follow[$];   // 0 = FCT closing a NULL, 1 = time byte

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_dat = 8'h00; m_lchar = 1'b0; m_credit = 0; m_err = 1'b0;
    m_fpend = 0; m_tpend = 1'b0; m_time = 8'h00;
    follow.delete();
  endtask

  function automatic bit pred_take();
    bit ld;
    ld = !m_valid || ready_i;
    return ld && en_i && (follow.size() == 0) && !(m_tpend && run_i) &&
           !(m_fpend > 0 && fct_en_i) && run_i && nc_valid_i && (m_credit > 0);
  endfunction

  task automatic model_step();
    bit ld, tk, fl, tc;
    int e, net;
    logic [7:0] nd;
    ld = !m_valid || ready_i;
    tk = pred_take();
    fl = 1'b0;
    tc = 1'b0;
    if (ld) begin
      if (!en_i) begin
        m_valid = 1'b0;
        follow.delete();
      end else begin
        m_valid = 1'b1;
        if (follow.size() > 0) begin
          e = follow.pop_front();
          if (e == 0) begin m_dat = 8'h00; m_lchar = 1'b1; end
          else begin m_dat = m_time; m_lchar = 1'b0; tc = 1'b1; end
        end else if (m_tpend && run_i) begin
          m_dat = 8'h03; m_lchar = 1'b1; follow.push_back(1);
        end else if (m_fpend > 0 && fct_en_i) begin
          m_dat = 8'h00; m_lchar = 1'b1; fl = 1'b1;
        end else if (tk) begin
          nd = nc_dat_i;
          if (nc_lchar_i) nd = {6'b000000, nd[1:0]};
          m_dat = nd; m_lchar = nc_lchar_i;
        end else begin
          m_dat = 8'h03; m_lchar = 1'b1; follow.push_back(0);
        end
      end
    end
    if (!en_i) m_tpend = 1'b0;
    else if (tick_i) m_tpend = 1'b1;
    else if (tc) m_tpend = 1'b0;
    if (tick_i) m_time = time_i;
    if (!en_i) m_fpend = 0;
    else if (fct_req_i && !fl) m_fpend = (m_fpend < 7) ? m_fpend + 1 : 7;
    else if (!fct_req_i && fl) m_fpend = m_fpend - 1;
    if (!en_i) begin
      m_credit = 0; m_err = 1'b0;
    end else begin
      net = m_credit + (fct_rx_i ? 8 : 0) - (tk ? 1 : 0);
      if (fct_rx_i && net > 56) m_err = 1'b1;
      else m_credit = net;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge txClk);
    chk("valid_o", 32'(valid_o), 32'(m_valid));
    chk("dat_o", 32'(dat_o), 32'(m_dat));
    chk("lchar_o", 32'(lchar_o), 32'(m_lchar));
    chk("credit_o", 32'(credit_o), 32'(m_credit));
    chk("credit_err_o", 32'(credit_err_o), 32'(m_err));
    chk("nc_ready_o", 32'(nc_ready_o), 32'(pred_take()));
    n_rdy += int'(nc_ready_o);
    @(posedge txClk);
    model_step();
    #1;
  endtask

  logic [7:0] hold_dat;
  logic       hold_lchar;

  initial begin
    txReset_n = 1'b0; en_i = 1'b0; fct_en_i = 1'b0; run_i = 1'b0; tick_i = 1'b0;
    time_i = 8'h00; fct_req_i = 1'b0; fct_rx_i = 1'b0; nc_valid_i = 1'b0;
    nc_dat_i = 8'h00; nc_lchar_i = 1'b0; ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge txClk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_credit", 32'(credit_o), 32'd0);
    chk("rst_nc_ready", 32'(nc_ready_o), 32'd0);
    txReset_n = 1'b1;

    // NULL stream on an idle enabled link
    en_i = 1'b1; ready_i = 1'b1;
    repeat (6) cycle();

    // queued FCTs interleave with NULLs without splitting them
    fct_en_i = 1'b1;
    fct_req_i = 1'b1; cycle();
    cycle();
    fct_req_i = 1'b0;
    repeat (8) cycle();

    // one credit grant lets exactly eight N-chars through
    run_i = 1'b1; nc_valid_i = 1'b1; fct_rx_i = 1'b1;
    n_rdy = 0;
    cycle();
    fct_rx_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      nc_dat_i = 8'($urandom);
      nc_lchar_i = ($urandom % 4) == 0;
      cycle();
    end
    chk("nc_ready_count", 32'(n_rdy), 32'd8);
    chk("credit_spent", 32'(credit_o), 32'd0);

    // time-code pre-empts a pending FCT during an N-char stream
    fct_rx_i = 1'b1; cycle(); fct_rx_i = 1'b0;
    repeat (3) cycle();
    tick_i = 1'b1; time_i = 8'h5A; fct_req_i = 1'b1;
    cycle();
    tick_i = 1'b0; fct_req_i = 1'b0;
    repeat (8) cycle();
    nc_valid_i = 1'b0; run_i = 1'b0;

    // credit ramps to the limit, the eighth grant overflows
    en_i = 1'b0; cycle(); en_i = 1'b1; cycle();
    for (int k = 1; k <= 8; k++) begin
      fct_rx_i = 1'b1; cycle(); fct_rx_i = 1'b0;
      chk("credit_ramp", 32'(credit_o), (k < 8) ? 32'(8 * k) : 32'd56);
      chk("credit_err_ramp", 32'(credit_err_o), (k == 8) ? 32'd1 : 32'd0);
      cycle();
    end
    en_i = 1'b0; cycle();
    chk("credit_clr", 32'(credit_o), 32'd0);
    chk("credit_err_clr", 32'(credit_err_o), 32'd0);
    en_i = 1'b1; repeat (2) cycle();

    // back-pressure holds the presented character
    ready_i = 1'b0;
    cycle();
    hold_dat = dat_o; hold_lchar = lchar_o;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_dat", 32'(dat_o), 32'(hold_dat));
      chk("hold_lchar", 32'(lchar_o), 32'(hold_lchar));
    end
    ready_i = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en_i       = ($urandom % 40) != 0;
      fct_en_i   = ($urandom % 3) != 0;
      run_i      = ($urandom % 4) != 0;
      tick_i     = ($urandom % 15) == 0;
      time_i     = 8'($urandom);
      fct_req_i  = ($urandom % 5) == 0;
      fct_rx_i   = ($urandom % 9) == 0;
      nc_valid_i = ($urandom % 3) != 0;
      nc_dat_i   = 8'($urandom);
      nc_lchar_i = ($urandom % 8) == 0;
      ready_i    = ($urandom % 4) != 0;
      cycle();
    end

    // asynchronous reset in the middle of a time-code
    en_i = 1'b1; run_i = 1'b1; ready_i = 1'b1; fct_en_i = 1'b0; fct_req_i = 1'b0;
    nc_valid_i = 1'b0; fct_rx_i = 1'b1; tick_i = 1'b0;
    cycle();
    fct_rx_i = 1'b0; tick_i = 1'b1; time_i = 8'hA5;
    cycle();
    tick_i = 1'b0;
    cycle();
    chk("pre_rst_credit", 32'(credit_o), 32'(m_credit));
    #2 txReset_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid_o), 32'd0);
    chk("async_credit", 32'(credit_o), 32'd0);
    chk("async_nc_ready", 32'(nc_ready_o), 32'd0);
    model_reset();
    @(posedge txClk);
    #1 txReset_n = 1'b1;
    en_i = 1'b1; run_i = 1'b0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
